// File: rtl/ul4_pkg.sv
// Shared definitions for the ul4 logic unit and its sequential initiator:
// command opcodes, logic-unit select codes and the controller state encoding.
package ul4_pkg;

   // Command opcodes seen on cmd_op. Values 0..3 are logic ops whose low two
   // bits are passed straight through as the logic-unit select.
   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NOT  = 3'd3;
   localparam logic [2:0] OP_LOAD = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;

   // Logic-unit select codes, bitwise: AND, OR, XOR, NOT A.
   localparam logic [1:0] SEL_AND = 2'b00;
   localparam logic [1:0] SEL_OR  = 2'b01;
   localparam logic [1:0] SEL_XOR = 2'b10;
   localparam logic [1:0] SEL_NOT = 2'b11;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // A logic op is any opcode with the top bit clear.
   function automatic logic is_logic_op(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   // Opcodes 6 and 7 are not defined and are reported as errors.
   function automatic logic is_illegal_op(input logic [2:0] op);
      return (op[2] == 1'b1) && (op[1] == 1'b1);
   endfunction

endpackage : ul4_pkg

// File: rtl/ul4_ctrl.sv
// Sequential initiator for the 4-bit logic unit. Holds the accumulator,
// accepts one command at a time, drives ACC/operand/select to the external
// combinational unit, captures its result and returns ACC on a response
// channel. All outputs come straight from flops.
module ul4_ctrl
   import ul4_pkg::*;
#(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             reset_n,
   // command channel
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [3:0]       cmd_data,
   // logic-unit interface
   output logic [3:0]       ul_a,
   output logic [3:0]       ul_b,
   output logic [1:0]       ul_s,
   input  logic [3:0]       ul_out,
   // response channel
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_data,
   output logic             rsp_zero,
   output logic             rsp_err,
   // statistics
   output logic [CNT_W-1:0] op_count
);

   state_t             state_q,     state_d;
   logic [3:0]         acc_q,       acc_d;
   logic [2:0]         op_q,        op_d;
   logic [3:0]         operand_q,   operand_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q,   rsp_err_d;
   logic               zero_q,      zero_d;

   logic               cmd_fire;
   logic               rsp_fire;

   // A transfer happens only when both sides agree; rsp_ready with no
   // response pending is ignored because rsp_valid_q gates it.
   assign cmd_fire = cmd_valid   && cmd_ready_q;
   assign rsp_fire = rsp_valid_q && rsp_ready;

   // Next-state and datapath update for the IDLE/ISSUE/RESP sequence.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      op_d      = op_q;
      operand_d = operand_q;
      cnt_d     = cnt_q;
      rsp_err_d = rsp_err_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               op_d      = cmd_op;
               operand_d = cmd_data;
               if (is_logic_op(cmd_op)) begin
                  // Operand and select settle in the registers; the unit's
                  // result is captured one cycle later.
                  state_d = ISSUE;
               end else if (cmd_op == OP_LOAD) begin
                  acc_d   = cmd_data;
                  state_d = RESP;
               end else if (cmd_op == OP_CLR) begin
                  acc_d   = 4'd0;
                  state_d = RESP;
               end else begin
                  // Undefined opcode: ACC untouched, flagged in the response.
                  rsp_err_d = is_illegal_op(cmd_op);
                  state_d   = RESP;
               end
            end
         end

         ISSUE: begin
            acc_d   = ul_out;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = RESP;
         end

         RESP: begin
            // Response fields are held until the consumer takes them.
            if (rsp_fire) begin
               rsp_err_d = 1'b0;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d   = IDLE;
            rsp_err_d = 1'b0;
         end
      endcase

      // Handshake outputs are registered copies of the upcoming state so
      // they change exactly on the same edge as the state itself.
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      zero_d      = (acc_d == 4'd0);
   end

   // State, datapath and output registers; reset aborts any command in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         acc_q       <= 4'd0;
         op_q        <= 3'd0;
         operand_q   <= 4'd0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         op_q        <= op_d;
         operand_q   <= operand_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         zero_q      <= zero_d;
      end
   end

   // The unit always sees the live accumulator plus the latched operand and
   // select, so its inputs are stable for the whole ISSUE cycle.
   assign ul_a      = acc_q;
   assign ul_b      = operand_q;
   assign ul_s      = op_q[1:0];

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = acc_q;
   assign rsp_zero  = zero_q;
   assign rsp_err   = rsp_err_q;
   assign op_count  = cnt_q;

endmodule : ul4_ctrl

// File: doc/ul4_ctrl.md
Name: ul4_ctrl

Overview:
- Sequential initiator for the 4-bit logic unit (ul4).
- Accepts commands over a valid/ready handshake and holds a 4-bit accumulator (ACC).
- For each logic command it drives ACC, an operand and a select code into the logic unit, captures the unit's result back into ACC, and returns it on a valid/ready response channel.
- Sits between the test/control sequencer and the combinational ul4.

Parameters:
- CNT_W, 8, width of the completed-logic-operation counter.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  opcode: 0..3 = logic op, S=cmd_op[1:0]; 4 = LOAD; 5 = CLEAR; 6,7 = illegal.
- cmd_data  in  4  operand B, or LOAD value.
- ul_a  out  4  operand A to the logic unit; always equals ACC.
- ul_b  out  4  operand B to the logic unit (registered operand).
- ul_s  out  2  select to the logic unit (registered op[1:0]).
- ul_out  in  4  combinational result from the logic unit.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  4  ACC after the command.
- rsp_zero  out  1  rsp_data == 0.
- rsp_err  out  1  the command was illegal.
- op_count  out  CNT_W  number of completed logic ops; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - ACC=0, op/operand registers=0, state=IDLE.
  - cmd_ready=0 during reset, 1 in IDLE afterwards.
  - rsp_valid=0, rsp_err=0, op_count=0, ul_a=ul_b=0, ul_s=0.
- Reset asserted mid-operation aborts the command. No response is produced and ACC returns to 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_op and cmd_data.
  - op 0..3 -> ISSUE.
  - LOAD -> ACC<=cmd_data, go RESP.
  - CLEAR -> ACC<=0, go RESP.
  - op 6/7 -> rsp_err<=1, ACC unchanged, go RESP.
- ISSUE:
  - One cycle; ul_a/ul_b/ul_s are stable from registers.
  - At the closing edge: ACC<=ul_out, op_count<=op_count+1, go RESP.
- RESP:
  - rsp_valid=1; rsp_data=ACC, rsp_zero=(ACC==0), rsp_err held.
  - All response signals stay stable until rsp_ready.
  - On rsp_valid&rsp_ready: clear rsp_err, go IDLE.
- cmd_ready=0 outside IDLE. Commands presented then are not consumed; the source holds them.
- Latency (accept edge = t):
  - Logic op: rsp_valid at t+2.
  - LOAD/CLEAR/illegal: rsp_valid at t+1.
  - Zero-wait back-to-back throughput: one logic op per 3 cycles.
- rsp_ready may be held high permanently; the response then lasts exactly one cycle.
- rsp_ready while rsp_valid=0 is ignored.
- op_count wraps from 2^CNT_W-1 to 0 without flagging.
- Logic-unit encoding used for checking, per bit: S=00 AND, 01 OR, 10 XOR, 11 NOT A.

Decomposition:
- Package ul4_pkg holds:
  - opcode constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3, OP_LOAD=4, OP_CLR=5;
  - state encoding IDLE/ISSUE/RESP;
  - the S select constants shared with ul4.
- No sub-module required. ul4 is instantiated externally (in the testbench or top level), not inside this block.

Test Plan:
- Reset then LOAD 4'b1010, rsp_ready=1 -> rsp_valid at t+1, rsp_data=1010, rsp_zero=0, rsp_err=0, op_count=0.
- ACC=1010; AND b=0110 -> at t+2 rsp_data=0010. Then XOR b=0010 -> rsp_data=0000, rsp_zero=1, op_count=2.
- ACC=0011; NOT -> rsp_data=1100. OR b=0001 -> 1101. Check during ISSUE: ul_a=ACC, ul_b=operand, ul_s matches opcode.
- Backpressure: rsp_ready=0 for 5 cycles after a response -> rsp_valid and rsp_data stable, cmd_ready=0, a pending cmd_valid is not consumed. Release -> IDLE, then the pending command is accepted.
- Illegal op 7 with ACC=0101 -> rsp_err=1, rsp_data=0101, op_count unchanged. Next legal command -> rsp_err=0.
- Assert reset_n=0 during ISSUE -> outputs immediately at reset values, no response. Run 256 logic ops -> op_count wraps to 0.
